// File: rtl/dbus_initiator_pkg.sv
// Shared encodings for the data-bus initiator: access sizes, FSM states,
// reset values and the request decode check.
package dbus_initiator_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WREQ  = 3'd1,
        ST_RREQ  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] RST_WORD = 32'h0000_0000;
    localparam logic [3:0]  RST_STRB = 4'h0;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // Misaligned half/word or the reserved size code never reach the bus.
    function automatic logic decode_err(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: decode_err = 1'b0;
            SIZE_HALF: decode_err = addr_lo[0];
            SIZE_WORD: decode_err = (addr_lo != 2'b00);
            default:   decode_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_initiator_if.sv
// Host request/response handshake plus peripheral read/write channels.
interface dbus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wready;
    logic        wvalid;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rready;
    logic        rvalid;
    logic [31:0] raddr;
    logic        rresp;
    logic [31:0] rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  wvalid, rvalid, rresp, rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output wready, waddr, wdata, wstrb, rready, raddr
    );

    modport slave (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output wvalid, rvalid, rresp, rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wready, waddr, wdata, wstrb, rready, raddr
    );
endinterface

// File: rtl/dbus_initiator_lane.sv
// Byte-lane steering: store strobes/replication and load shift/extension.
module dbus_initiator_lane
    import dbus_initiator_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  strb,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);
    logic [31:0] shifted_s;

    assign shifted_s = load_word >> {addr_lo, 3'b000};

    // Store side: enables and replicated data per access size.
    always_comb begin
        strb        = RST_STRB;
        store_lanes = RST_WORD;
        case (size)
            SIZE_BYTE: begin
                strb        = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                strb        = 4'b0011 << addr_lo;
                store_lanes = {2{store_data[15:0]}};
            end
            SIZE_WORD: begin
                strb        = 4'b1111;
                store_lanes = store_data;
            end
            default: begin
                strb        = RST_STRB;
                store_lanes = RST_WORD;
            end
        endcase
    end

    // Load side: right-justified field, then sign or zero extension.
    always_comb begin
        load_data = shifted_s;
        case (size)
            SIZE_BYTE: load_data = is_unsigned ? {24'h000000, shifted_s[7:0]}
                                               : {{24{shifted_s[7]}}, shifted_s[7:0]};
            SIZE_HALF: load_data = is_unsigned ? {16'h0000, shifted_s[15:0]}
                                               : {{16{shifted_s[15]}}, shifted_s[15:0]};
            default:   load_data = shifted_s;
        endcase
    end
endmodule

// File: rtl/dbus_initiator.sv
// Data-bus initiator: one load/store at a time from the memory stage to the
// peripheral bus, with decode checks and a bus timeout.
module dbus_initiator
    import dbus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              resetb,
    dbus_initiator_if.master bus
);
    localparam logic [15:0] TIMEOUT_L = TIMEOUT[15:0];

    state_e      state_r, state_next_s;
    logic [15:0] cnt_r, cnt_inc_s;
    logic [1:0]  size_r, addr_lo_r;
    logic        unsigned_r;
    logic        accept_s, timeout_s, in_bus_s;

    logic        req_ready_r, wready_r, rready_r, rsp_valid_r, rsp_err_r;
    logic [31:0] rsp_rdata_r, waddr_r, wdata_r, raddr_r;
    logic [3:0]  wstrb_r;
    logic        req_ready_nxt_s, wready_nxt_s, rready_nxt_s, rsp_valid_nxt_s, rsp_err_nxt_s;
    logic [31:0] rsp_rdata_nxt_s, waddr_nxt_s, wdata_nxt_s, raddr_nxt_s;
    logic [3:0]  wstrb_nxt_s;

    logic [3:0]  lane_strb_s;
    logic [31:0] lane_wdata_s, lane_load_s;

    assign accept_s  = req_ready_r & bus.req_valid;
    assign in_bus_s  = (state_r == ST_WREQ) | (state_r == ST_RREQ) | (state_r == ST_RWAIT);
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 16'd1;
    assign timeout_s = (cnt_inc_s >= TIMEOUT_L);

    // In IDLE the lanes see the incoming store; afterwards the latched load.
    dbus_initiator_lane u_lane (
        .size        ((state_r == ST_IDLE) ? bus.req_size : size_r),
        .addr_lo     ((state_r == ST_IDLE) ? bus.req_addr[1:0] : addr_lo_r),
        .is_unsigned (unsigned_r),
        .store_data  (bus.req_wdata),
        .load_word   (bus.rdata),
        .strb        (lane_strb_s),
        .store_lanes (lane_wdata_s),
        .load_data   (lane_load_s)
    );

    // State register, timeout counter and latched load attributes.
    always_ff @(posedge clk) begin
        if (resetb) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'h0000;
            size_r     <= 2'b00;
            addr_lo_r  <= 2'b00;
            unsigned_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                cnt_r      <= 16'h0000;
                size_r     <= bus.req_size;
                addr_lo_r  <= bus.req_addr[1:0];
                unsigned_r <= bus.req_unsigned;
            end else if (in_bus_s) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state decode; a response in the same cycle as the timeout wins.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s)                                        state_next_s = ST_IDLE;
                else if (decode_err(bus.req_size, bus.req_addr[1:0])) state_next_s = ST_DONE;
                else if (bus.req_we)                                  state_next_s = ST_WREQ;
                else                                                  state_next_s = ST_RREQ;
            end
            ST_WREQ:  state_next_s = (bus.wvalid || timeout_s) ? ST_DONE : ST_WREQ;
            ST_RREQ: begin
                if (bus.rvalid)     state_next_s = ST_RWAIT;
                else if (timeout_s) state_next_s = ST_DONE;
                else                state_next_s = ST_RREQ;
            end
            ST_RWAIT: state_next_s = (bus.rresp || timeout_s) ? ST_DONE : ST_RWAIT;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, registered below.
    always_comb begin
        req_ready_nxt_s = (state_next_s == ST_IDLE);
        wready_nxt_s    = (state_next_s == ST_WREQ);
        rready_nxt_s    = (state_next_s == ST_RREQ);
        rsp_valid_nxt_s = (state_next_s == ST_DONE);
        rsp_err_nxt_s   = (state_next_s == ST_DONE) &&
                          !((state_r == ST_WREQ && bus.wvalid) || (state_r == ST_RWAIT && bus.rresp));
        rsp_rdata_nxt_s = (state_next_s == ST_DONE && state_r == ST_RWAIT && bus.rresp)
                          ? lane_load_s : RST_WORD;
        if (state_r == ST_IDLE && state_next_s == ST_WREQ) begin
            waddr_nxt_s = {bus.req_addr[31:2], 2'b00};
            wdata_nxt_s = lane_wdata_s;
            wstrb_nxt_s = lane_strb_s;
        end else begin
            waddr_nxt_s = waddr_r;
            wdata_nxt_s = wdata_r;
            wstrb_nxt_s = wstrb_r;
        end
        if (state_r == ST_IDLE && state_next_s == ST_RREQ) begin
            raddr_nxt_s = {bus.req_addr[31:2], 2'b00};
        end else begin
            raddr_nxt_s = raddr_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (resetb) begin
            req_ready_r <= 1'b0;
            wready_r    <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= RST_WORD;
            waddr_r     <= RST_WORD;
            wdata_r     <= RST_WORD;
            wstrb_r     <= RST_STRB;
            raddr_r     <= RST_WORD;
        end else begin
            req_ready_r <= req_ready_nxt_s;
            wready_r    <= wready_nxt_s;
            rready_r    <= rready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            waddr_r     <= waddr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            wstrb_r     <= wstrb_nxt_s;
            raddr_r     <= raddr_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.wready    = wready_r;
    assign bus.rready    = rready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.waddr     = waddr_r;
    assign bus.wdata     = wdata_r;
    assign bus.wstrb     = wstrb_r;
    assign bus.raddr     = raddr_r;
endmodule

// File: tb/tb_dbus_initiator.sv
// Randomized bench: byte-level memory reference model plus a timer-like responder.
module tb_dbus_initiator;
    localparam int          TO            = 8;
    localparam logic [31:0] MTIME_BASE    = 32'h0200_BFF8;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0200_4000;

    logic clk = 1'b0;
    logic resetb;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    dbus_initiator_if bus_if ();
    dbus_initiator #(.TIMEOUT(TO)) dut (.clk(clk), .resetb(resetb), .bus(bus_if));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic bad_req(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'd3) || ((addr % nbytes(sz)) != 0);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        return mem.exists(wa) ? mem[wa] : 32'h0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem.exists(a & ~32'd3) ? ref_mem[a & ~32'd3] : 32'h0;
        return w[int'(a[1:0]) * 8 +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + i);
        for (int i = n; i < 4; i++) v[8*i +: 8] = (uns || !v[8*n-1]) ? 8'h00 : 8'hFF;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w, ba;
        for (int i = 0; i < nbytes(sz); i++) begin
            ba = a + i;
            w  = ref_mem.exists(ba & ~32'd3) ? ref_mem[ba & ~32'd3] : 32'h0;
            w[int'(ba[1:0]) * 8 +: 8] = d[8*i +: 8];
            ref_mem[ba & ~32'd3] = w;
        end
    endtask

    // mode 0: responder answers after dly cycles; 1: never accepts; 2: accepts read, no data
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                           input int dly, input int mode);
        logic        err_e, bus_e;
        logic [31:0] rd_e, wd_e, rd_addr, w;
        logic [3:0]  strb_e;
        int          lat_e, waited, n;
        bit          saw_w, saw_r, done, pend;
        err_e = bad_req(sz, addr);
        bus_e = !err_e;
        rd_e  = 32'h0;
        n     = nbytes(sz);
        strb_e = 4'h0;
        wd_e   = 32'h0;
        for (int i = 0; i < n; i++) strb_e[int'(addr[1:0]) + i] = 1'b1;
        for (int j = 0; j < 4; j++) wd_e[8*j +: 8] = wd[8*(j % n) +: 8];
        if (err_e)          lat_e = 1;
        else if (mode != 0) begin err_e = 1'b1; lat_e = TO + 1; end
        else if (we)        begin lat_e = 2 + dly; ref_store(addr, sz, wd); end
        else                begin lat_e = 3 + dly; rd_e = ref_load(addr, sz, uns); end

        check_eq({tag, ".req_ready"}, {31'h0, bus_if.req_ready}, 32'h1);
        bus_if.req_valid = 1'b1; bus_if.req_we = we; bus_if.req_addr = addr;
        bus_if.req_size = sz; bus_if.req_unsigned = uns; bus_if.req_wdata = wd;
        tick();
        bus_if.req_valid = 1'b0; bus_if.req_addr = $urandom; bus_if.req_wdata = $urandom;
        bus_if.req_size = 2'($urandom_range(0, 3)); bus_if.req_unsigned = 1'($urandom);
        waited = 0; saw_w = 0; saw_r = 0; done = 0; pend = 0; rd_addr = 32'h0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            bus_if.wvalid = 1'b0; bus_if.rvalid = 1'b0; bus_if.rresp = 1'b0;
            bus_if.rdata  = $urandom;
            if (pend) begin
                pend = 0;
                if (mode == 0) begin bus_if.rresp = 1'b1; bus_if.rdata = mem_rd(rd_addr); end
            end
            if (bus_if.rsp_valid) begin
                done = 1;
                check_eq({tag, ".err"}, {31'h0, bus_if.rsp_err}, {31'h0, err_e});
                check_eq({tag, ".rdata"}, bus_if.rsp_rdata, rd_e);
                check_eq({tag, ".latency"}, cyc, lat_e);
            end else begin
                if (bus_if.wready) begin
                    if (!saw_w) begin
                        check_eq({tag, ".waddr"}, bus_if.waddr, addr & ~32'd3);
                        check_eq({tag, ".wstrb"}, {28'h0, bus_if.wstrb}, {28'h0, strb_e});
                        check_eq({tag, ".wdata"}, bus_if.wdata, wd_e);
                    end
                    saw_w = 1;
                    if (mode == 0 && waited == dly) begin
                        bus_if.wvalid = 1'b1;
                        w = mem_rd(bus_if.waddr);
                        for (int b = 0; b < 4; b++)
                            if (bus_if.wstrb[b]) w[8*b +: 8] = bus_if.wdata[8*b +: 8];
                        mem[bus_if.waddr] = w;
                    end
                    waited++;
                end
                if (bus_if.rready) begin
                    if (!saw_r) check_eq({tag, ".raddr"}, bus_if.raddr, addr & ~32'd3);
                    saw_r = 1;
                    if (mode != 1 && waited == dly) begin
                        bus_if.rvalid = 1'b1; pend = 1; rd_addr = bus_if.raddr;
                    end
                    waited++;
                end
                tick();
            end
        end
        bus_if.wvalid = 1'b0; bus_if.rvalid = 1'b0; bus_if.rresp = 1'b0;
        if (!done) check_eq({tag, ".no_response"}, 32'h0, 32'h1);
        check_eq({tag, ".saw_wready"}, {31'h0, saw_w}, {31'h0, bus_e && we});
        check_eq({tag, ".saw_rready"}, {31'h0, saw_r}, {31'h0, bus_e && !we});
        tick();
        check_eq({tag, ".pulse"}, {31'h0, bus_if.rsp_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        resetb = 1'b1;
        bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_addr = 32'h0;
        bus_if.req_size = 2'd0; bus_if.req_unsigned = 1'b0; bus_if.req_wdata = 32'h0;
        bus_if.wvalid = 1'b0; bus_if.rvalid = 1'b0; bus_if.rresp = 1'b0; bus_if.rdata = 32'h0;
        tick(); tick();
        check_eq("rst.req_ready", {31'h0, bus_if.req_ready}, 32'h0);
        check_eq("rst.flags", {28'h0, bus_if.wready, bus_if.rready, bus_if.rsp_valid, bus_if.rsp_err}, 32'h0);
        check_eq("rst.rsp_rdata", bus_if.rsp_rdata, 32'h0);
        check_eq("rst.waddr", bus_if.waddr, 32'h0);
        check_eq("rst.raddr", bus_if.raddr, 32'h0);
        check_eq("rst.wdata", bus_if.wdata, 32'h0);
        check_eq("rst.wstrb", {28'h0, bus_if.wstrb}, 32'h0);
        resetb = 1'b0;
        tick();
        check_eq("rst.req_ready_after", {31'h0, bus_if.req_ready}, 32'h1);

        // Stray responder activity while idle must be ignored.
        bus_if.wvalid = 1'b1; bus_if.rvalid = 1'b1; bus_if.rresp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle.stray", {29'h0, bus_if.wready, bus_if.rready, bus_if.rsp_valid}, 32'h0);
        end
        bus_if.wvalid = 1'b0; bus_if.rvalid = 1'b0; bus_if.rresp = 1'b0;

        run_txn("st_word_mtime", 1'b1, MTIME_BASE, 2'd2, 1'b0, 32'h1234_5678, 0, 0);
        run_txn("ld_word_mtime", 1'b0, MTIME_BASE, 2'd2, 1'b0, 32'h0, 0, 0);
        mem[MTIMECMP_BASE] = 32'h80A5_5A11;
        ref_mem[MTIMECMP_BASE] = 32'h80A5_5A11;
        run_txn("lbu_cmp3", 1'b0, MTIMECMP_BASE + 32'd3, 2'd0, 1'b1, 32'h0, 0, 0);
        run_txn("lb_cmp3", 1'b0, MTIMECMP_BASE + 32'd3, 2'd0, 1'b0, 32'h0, 0, 0);
        run_txn("sh_cmp2", 1'b1, MTIMECMP_BASE + 32'd2, 2'd1, 1'b0, 32'h0000_BEEF, 1, 0);
        run_txn("lw_cmp", 1'b0, MTIMECMP_BASE, 2'd2, 1'b0, 32'h0, 2, 0);
        run_txn("lh_misalign", 1'b0, MTIMECMP_BASE + 32'd1, 2'd1, 1'b0, 32'h0, 0, 0);
        run_txn("size3", 1'b1, MTIMECMP_BASE, 2'd3, 1'b0, 32'hFFFF_FFFF, 0, 0);
        run_txn("ld_timeout", 1'b0, MTIME_BASE, 2'd2, 1'b0, 32'h0, 0, 1);
        run_txn("rwait_timeout", 1'b0, MTIME_BASE, 2'd2, 1'b0, 32'h0, 2, 2);
        run_txn("st_timeout", 1'b1, MTIME_BASE, 2'd0, 1'b0, 32'h55, 0, 1);

        // Reset pulsed while waiting for read data.
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_addr = MTIME_BASE;
        bus_if.req_size = 2'd2; bus_if.req_unsigned = 1'b0;
        tick();
        bus_if.req_valid = 1'b0;
        check_eq("rstmid.rready", {31'h0, bus_if.rready}, 32'h1);
        bus_if.rvalid = 1'b1;
        tick();
        bus_if.rvalid = 1'b0;
        check_eq("rstmid.rwait", {30'h0, bus_if.rready, bus_if.rsp_valid}, 32'h0);
        resetb = 1'b1;
        tick();
        resetb = 1'b0; bus_if.rresp = 1'b1; bus_if.rdata = 32'hDEAD_BEEF;
        check_eq("rstmid.quiet", {28'h0, bus_if.req_ready, bus_if.wready, bus_if.rready, bus_if.rsp_valid}, 32'h0);
        tick();
        bus_if.rresp = 1'b0;
        check_eq("rstmid.stray_rresp", {31'h0, bus_if.rsp_valid}, 32'h0);
        check_eq("rstmid.ready", {31'h0, bus_if.req_ready}, 32'h1);
        run_txn("rstmid.next_load", 1'b0, MTIME_BASE + 32'd2, 2'd1, 1'b0, 32'h0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            a = (($urandom_range(0, 1) != 0) ? MTIME_BASE : MTIMECMP_BASE)
                + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", t), 1'($urandom), a, 2'($urandom_range(0, 3)),
                    1'($urandom), $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dbus_initiator.md
# dbus_initiator

Bus initiator for the data side of the core: accepts one load or store at a time from the memory stage and drives the peripheral bus. Generates aligned word address, byte strobes and lane-replicated store data, then returns a sign- or zero-extended load result. Peripherals such as the timer respond on the other end: they accept writes with `wvalid`, accept reads with `rvalid`, and return `rresp`/`rdata` one cycle after an accepted read. A timeout guards against a responder that never answers.

## Interface
- `TIMEOUT`, 255: cycles waiting in any bus state before aborting with error; 1..65535.
- `clk`  in  1  clock.
- `resetb`  in  1  synchronous, active-high reset (sampled on `clk` rising edge; 1 = reset).
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  initiator can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal.
- `req_unsigned`  in  1  zero-extend load (LBU/LHU).
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned/illegal size or timeout.
- `wready`  out  1  write request to responder.
- `wvalid`  in  1  responder accepts write.
- `waddr`  out  32  word address (`req_addr` with [1:0] cleared).
- `wdata`  out  32  lane-replicated store data.
- `wstrb`  out  4  byte enables.
- `rready`  out  1  read request to responder.
- `rvalid`  in  1  responder accepts read.
- `raddr`  out  32  word address.
- `rresp`  in  1  read data valid.
- `rdata`  in  32  read data.

## Operation
- States: IDLE, WREQ, RREQ, RWAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`: latch request. Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 3 → DONE with err, no bus activity. Else store → WREQ, load → RREQ.
- WREQ: `wready`=1 with `waddr/wdata/wstrb` stable. `wvalid` sampled high → DONE (err=0).
- RREQ: `rready`=1, `raddr` stable. `rvalid` high → RWAIT. `rready` drops the cycle after acceptance.
- RWAIT: `rresp` high → capture `rdata`, shift right by 8×addr[1:0], extend per size/unsigned → DONE.
- DONE: `rsp_valid`=1 for exactly one cycle with latched `rsp_rdata`/`rsp_err` → IDLE.
- Timeout: 16-bit counter cleared on leaving IDLE, increments in WREQ/RREQ/RWAIT; reaching `TIMEOUT` → DONE with err=1, rdata=0. Counter saturates, never wraps.
- Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. `wdata`: byte replicated ×4, half ×2, word as is.
- `rresp` or `rvalid`/`wvalid` arriving in IDLE or DONE are ignored.

## Timing
- Reset values: `req_ready`=0 during reset, 1 the cycle after; `wready`, `rready`, `rsp_valid`, `rsp_err`=0; `rsp_rdata`, `waddr`, `raddr`, `wdata`=0; `wstrb`=0; state IDLE; counter 0.
- Reset mid-transaction: abandon it, no response, bus requests low next cycle.
- Store, always-ready responder: request accepted at cycle 0, `wready` cycle 1, `rsp_valid` cycle 2.
- Load, one-cycle responder: accepted cycle 0, `rready` cycle 1, `rresp` cycle 2, `rsp_valid` cycle 3.
- Error on decode: `rsp_valid` cycle 1.
- All outputs registered; no combinational path from bus inputs to bus outputs.

## Structure
- Shared package/header: size encodings, state encodings, reset values; peripheral base addresses stay in `opcode.vh`.
- One sub-module natural: `dbus_lane` — combinational strobe/replication for stores and shift/extend for loads.

## Test plan
- Word store 0x12345678 to MTIME_BASE with timer as responder → `wstrb`=4'hF, `rsp_valid` cycle 2, timer low word reads back 0x12345678.
- Byte load, unsigned and signed, from MTIMECMP_BASE+3 holding 0x80xxxxxx → `rsp_rdata` 0x00000080 / 0xFFFFFF80, latency 3.
- Half store 0xBEEF at addr+2 → `wstrb`=4'b1100, `wdata`=0xBEEFBEEF, `waddr` word-aligned.
- Half load at addr+1 → `rsp_err`=1 at cycle 1, `wready`/`rready` never asserted.
- Responder holding `rvalid`=0, TIMEOUT=8 → `rsp_err`=1, `rsp_rdata`=0 after 8 cycles in RREQ, then IDLE.
- `resetb` pulsed during RWAIT → no `rsp_valid`, stray `rresp` next cycle ignored, next load completes normally.
